// File: rtl/prbs31_pkg.sv
// ============================================================================
// Module      : prbs31_pkg
// Description : Shared constants and state encoding for the PRBS31 checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prbs31_pkg;

    localparam int PRBS31_TAP_A    = 31;
    localparam int PRBS31_TAP_B    = 28;
    localparam int PRBS31_SEED_LEN = 31;

    typedef enum logic [1:0] {
        ST_SEED  = 2'd0,
        ST_CHECK = 2'd1,
        ST_LOST  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/prbs31_predictor.sv
// ============================================================================
// Module      : prbs31_predictor
// Description : 31-bit received-bit history, next-bit prediction and
//               all-zero detect for the x^31 + x^28 + 1 sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs31_predictor
    import prbs31_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic shift_en,
    input  logic din,
    output logic pred,
    output logic next_zero
);

    logic [PRBS31_TAP_A-1:0] s_q;
    logic [PRBS31_TAP_A-1:0] s_d;
    logic [PRBS31_TAP_A-1:0] s_shift;

    // The received bit is always shifted in, which makes the checker self-synchronising.
    always_comb begin
        s_shift = {s_q[PRBS31_TAP_A-2:0], din};
        s_d     = s_q;
        if (shift_en) begin
            s_d = s_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n || clear) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

    assign pred      = s_q[PRBS31_TAP_A-1] ^ s_q[PRBS31_TAP_B-1];
    assign next_zero = (s_shift == '0);

endmodule

`default_nettype wire

// File: rtl/prbs31_checker.sv
// ============================================================================
// Module      : prbs31_checker
// Description : Self-synchronising PRBS31 receive checker with lock FSM,
//               loss-of-lock window and saturating error counter.
//               Define PRBS31_CHK_AUTORESYNC_EN to re-seed automatically
//               after loss of lock; otherwise LOST is sticky.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs31_checker
    import prbs31_pkg::*;
#(
    parameter int ERR_W       = 16,
    parameter int WIN_LEN     = 64,
    parameter int LOSS_THRESH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int WB_W = $clog2(WIN_LEN);
    localparam int WE_W = $clog2(LOSS_THRESH + 1);

    state_e            state_q,     state_d;
    logic [4:0]        seed_cnt_q,  seed_cnt_d;
    logic [WB_W-1:0]   win_bit_q,   win_bit_d;
    logic [WE_W-1:0]   win_err_q,   win_err_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic              err_pulse_q, err_pulse_d;
    logic              locked_q,    locked_d;

    logic              pred;
    logic              next_zero;
    logic              mism;
    logic [WE_W-1:0]   win_err_inc;

    prbs31_predictor u_predictor (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .shift_en  (din_valid),
        .din       (din),
        .pred      (pred),
        .next_zero (next_zero)
    );

    always_comb begin
        state_d     = state_q;
        seed_cnt_d  = seed_cnt_q;
        win_bit_d   = win_bit_q;
        win_err_d   = win_err_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;
        mism        = din ^ pred;
        win_err_inc = win_err_q + WE_W'(mism);

        case (state_q)
            ST_SEED: begin
                if (din_valid) begin
                    if (seed_cnt_q == 5'(PRBS31_SEED_LEN - 1)) begin
                        seed_cnt_d = 5'd0;
                        if (!next_zero) begin
                            state_d   = ST_CHECK;
                            win_bit_d = '0;
                            win_err_d = '0;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + 5'd1;
                    end
                end
            end
            ST_CHECK: begin
                if (din_valid) begin
                    if (mism) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                    end
                    win_err_d = win_err_inc;
                    win_bit_d = win_bit_q + WB_W'(1);
                    // The wrapping bit still belongs to the old window for the threshold test.
                    if (win_bit_q == WB_W'(WIN_LEN - 1)) begin
                        win_bit_d = '0;
                        win_err_d = '0;
                    end
                    if ((win_err_inc == WE_W'(LOSS_THRESH)) || next_zero) begin
                        state_d = ST_LOST;
                    end
                end
            end
            ST_LOST: begin
`ifdef PRBS31_CHK_AUTORESYNC_EN
                state_d    = ST_SEED;
                seed_cnt_d = 5'd0;
`else
                state_d    = ST_LOST;
`endif
            end
            default: begin
                state_d    = ST_SEED;
                seed_cnt_d = 5'd0;
            end
        endcase

        locked_d = (state_d == ST_CHECK);
    end

    always_ff @(posedge clk) begin
        if (rst_n || clear) begin
            state_q     <= ST_SEED;
            seed_cnt_q  <= 5'd0;
            win_bit_q   <= '0;
            win_err_q   <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_cnt_q  <= seed_cnt_d;
            win_bit_q   <= win_bit_d;
            win_err_q   <= win_err_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_prbs31_checker.sv
// ============================================================================
// Module      : tb_prbs31_checker
// Description : Self-checking bench for prbs31_checker (default and ERR_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prbs31_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din;
    logic        din_valid;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        locked4;
    logic        err_pulse4;
    logic [3:0]  err_count4;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: bit history (index 0 = newest) plus behavioural state.
    int m_mode;      // 0 seeding, 1 checking, 2 lost
    int m_seed_n;
    int m_win_n;
    int m_win_err;
    int m_count;
    bit m_pulse;
    bit hist[$];

    logic [30:0] gen;
    bit          ever_locked;

    always #5 clk = ~clk;

    prbs31_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    prbs31_checker #(.ERR_W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .clear     (clear),
        .locked    (locked4),
        .err_pulse (err_pulse4),
        .err_count (err_count4)
    );

    task automatic gen_next(output bit b);
        b   = gen[30] ^ gen[27];
        gen = {gen[29:0], b};
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_seed_n  = 0;
        m_win_n   = 0;
        m_win_err = 0;
        m_count   = 0;
        m_pulse   = 0;
        hist.delete();
        for (int i = 0; i < 31; i++) hist.push_back(1'b0);
    endtask

    task automatic model_step(input bit v, input bit d);
        bit pred;
        bit allz;
        bit lost;
        m_pulse = 0;
        pred    = 0;
        if (v) begin
            // Sequence rule: bit n = bit(n-31) xor bit(n-28).
            pred = hist[30] ^ hist[27];
            hist.push_front(d);
            void'(hist.pop_back());
        end
        allz = 1;
        foreach (hist[i]) if (hist[i]) allz = 0;
        if (m_mode == 2) begin
`ifdef PRBS31_CHK_AUTORESYNC_EN
            m_mode   = 0;
            m_seed_n = 0;
`endif
        end else if (v && m_mode == 0) begin
            m_seed_n++;
            if (m_seed_n == 31) begin
                m_seed_n = 0;
                if (!allz) begin
                    m_mode    = 1;
                    m_win_n   = 0;
                    m_win_err = 0;
                end
            end
        end else if (v && m_mode == 1) begin
            if (d != pred) begin
                m_pulse = 1;
                if (m_count < 65535) m_count++;
                m_win_err++;
            end
            m_win_n++;
            lost = (m_win_err >= 8) || allz;
            if (m_win_n == 64) begin
                m_win_n   = 0;
                m_win_err = 0;
            end
            if (lost) m_mode = 2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input bit d, input bit c, input bit r);
        din_valid = v;
        din       = d;
        clear     = c;
        rst_n     = r;
        @(posedge clk);
        if (r || c) model_reset();
        else        model_step(v, d);
        #1;
        if (locked) ever_locked = 1;
        chk("locked",     {31'd0, locked},     {31'd0, (m_mode == 1)});
        chk("err_pulse",  {31'd0, err_pulse},  {31'd0, m_pulse});
        chk("err_count",  {16'd0, err_count},  m_count);
        chk("err_count4", {28'd0, err_count4}, (m_count > 15) ? 15 : m_count);
    endtask

    task automatic restart();
        gen = 31'h7FFFFFFF;
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        bit b;
        rst_n = 1'b1; clear = 1'b0; din = 1'b0; din_valid = 1'b0;

        // Reset with random line activity
        step($urandom_range(0, 1), $urandom_range(0, 1), 1'b0, 1'b1);
        step($urandom_range(0, 1), $urandom_range(0, 1), 1'b0, 1'b1);
        chk("reset_locked", {31'd0, locked}, 0);
        chk("reset_count",  {16'd0, err_count}, 0);

        // Clean stream
        gen = 31'h7FFFFFFF;
        for (int i = 0; i < 1000; i++) begin
            gen_next(b);
            step(1'b1, b, 1'b0, 1'b0);
            if (i == 30) chk("lock_after_31", {31'd0, locked}, 1);
        end
        chk("clean_count", {16'd0, err_count}, 0);

        // Single flipped bit
        restart();
        for (int i = 0; i < 300; i++) begin
            gen_next(b);
            step(1'b1, (i == 200) ? ~b : b, 1'b0, 1'b0);
        end
        chk("flip_count",  {16'd0, err_count}, 3);
        chk("flip_locked", {31'd0, locked}, 1);

        // Gapped valid
        restart();
        for (int i = 0; i < 1200; i++) begin
            if (i % 2 == 1) begin
                gen_next(b);
                step(1'b1, b, 1'b0, 1'b0);
            end else begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
        end
        chk("gapped_count",  {16'd0, err_count}, 0);
        chk("gapped_locked", {31'd0, locked}, 1);

        // Six spaced flips: 18 errors, narrow counter saturates
        restart();
        for (int i = 0; i < 700; i++) begin
            gen_next(b);
            step(1'b1, (i >= 100 && i % 100 == 0) ? ~b : b, 1'b0, 1'b0);
        end
        chk("multi_count",  {16'd0, err_count}, 18);
        chk("sat_count4",   {28'd0, err_count4}, 15);

        // Random data after lock
        restart();
        for (int i = 0; i < 40; i++) begin
            gen_next(b);
            step(1'b1, b, 1'b0, 1'b0);
        end
        for (int i = 0; i < 400 && m_mode == 1; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        chk("random_lost", {31'd0, locked}, 0);
        for (int i = 0; i < 100; i++) begin
            gen_next(b);
            step(1'b1, b, 1'b0, 1'b0);
        end
`ifdef PRBS31_CHK_AUTORESYNC_EN
        chk("resync_locked", {31'd0, locked}, 1);
`else
        chk("sticky_lost", {31'd0, locked}, 0);
`endif
        restart();
        for (int i = 0; i < 100; i++) begin
            gen_next(b);
            step(1'b1, b, 1'b0, 1'b0);
        end
        chk("relock_after_clear", {31'd0, locked}, 1);

        // All-zero stream never locks
        restart();
        ever_locked = 0;
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("zero_never_lock", {31'd0, ever_locked}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prbs31_checker.md
# prbs31_checker

Receive-side PRBS31 checker that pairs with the team's PRBS31 pattern generator. It takes the serial bit stream, self-synchronises to the x^31 + x^28 + 1 sequence, and counts bit errors. It reports lock status, a per-bit error strobe and a saturating error count. It sits behind the Tiny Tapeout top-level pin mux; pin mapping is the top-level's job.

## Interface
- `ERR_W`, default 16: width of the error counter.
- `WIN_LEN`, default 64: loss-of-lock observation window, in valid bits (power of two, ≥ 32).
- `LOSS_THRESH`, default 8: number of errors within one window that declares loss of lock.
- `clk`, input, 1: single clock; all logic on its rising edge.
- `rst_n`, input, 1: reset, synchronous, active-high (`rst_n` = 1 resets).
- `din`, input, 1: received serial bit.
- `din_valid`, input, 1: `din` is sampled on an edge only when this is 1.
- `clear`, input, 1: synchronous restart; zeroes counters and re-seeds. Lower priority than `rst_n`.
- `locked`, output, 1: checker is in CHECK.
- `err_pulse`, output, 1: one-cycle strobe for a mismatched bit.
- `err_count`, output, `ERR_W`: total mismatches since reset or clear; saturating.

## Operation
- Shift register `s[30:0]`, where `s[0]` is the newest received bit. The predicted bit is `s[30] ^ s[27]`.
  - Every valid bit shifts in the received `din`, never the predicted bit (self-synchronising).
  - Consequence: one flipped line bit produces 3 errors, at offsets 0, +28 and +31.
- State machine:
  - **SEED** (reset state): the seed counter counts valid bits 0..30, with no comparison.
    - On the 31st valid bit, go to CHECK if the resulting `s` is non-zero.
    - If `s` is all-zero, restart SEED with the seed counter at 0.
  - **CHECK**: each valid bit is compared with the prediction.
    - On a mismatch, assert `err_pulse`, increment `err_count` (it holds at all-ones) and increment the window error counter.
    - The window bit counter wraps at `WIN_LEN`; at wrap the window error counter returns to 0.
    - When the window error count reaches `LOSS_THRESH`, go to LOST.
    - When `s` becomes all-zero (31 consecutive zeros), go to LOST.
  - **LOST**: behaviour depends on `PRBS31_CHK_AUTORESYNC_EN` (see Configuration).
- `err_count` increments only in CHECK and is never cleared by LOST; only `rst_n` or `clear` zero it.
- Simultaneous events:
  - A mismatch on the bit that also trips `LOSS_THRESH` is still counted.
  - A window wrap on the same edge as an error: the error is counted in the old window, then the window resets.
- `clear` and `rst_n` mid-stream: state becomes SEED, seed counter, window counters, `err_count` and `s` go to 0, and the current `din` is discarded.
- `din_valid` = 0: no state, counter or shift-register change; `err_pulse` = 0.

## Timing
- Reset values: `locked` = 0, `err_pulse` = 0, `err_count` = 0, state SEED.
- All outputs are registered and updated on the edge that samples the relevant bit; they are visible in the following cycle.
- `locked` rises on the edge that samples the 31st seed bit. The first compared bit is the 32nd valid bit.
- `err_pulse` is high for exactly one cycle per erroneous bit. It can be high on consecutive cycles if consecutive bits are erroneous.
- `locked` falls on the edge that samples the bit triggering LOST.
- Throughput: one bit per clock when `din_valid` is held high. There is no backpressure.

## Configuration
- `PRBS31_CHK_AUTORESYNC_EN` defined:
  - LOST lasts exactly one cycle, then the block enters SEED with the seed counter at 0.
  - Re-lock happens 31 valid bits later.
- Not defined:
  - LOST is sticky; `locked` = 0 and `err_count` is frozen.
  - Only `clear` or `rst_n` exits LOST.

## Structure
- Package `prbs31_pkg` holds:
  - Tap constants `PRBS31_TAP_A = 31` and `PRBS31_TAP_B = 28`.
  - The state enum: SEED, CHECK, LOST.
  - The seed length constant 31.
- One sub-module, `prbs31_predictor`: the 31-bit shift register, the predicted-bit XOR and the all-zero detect. It is shared with the generator's test model.
- The top module holds the FSM, the window counters and the error counter.

## Test plan
- Reset: hold `rst_n` = 1 for 2 cycles with random `din` → `locked` = 0, `err_pulse` = 0, `err_count` = 0.
- Clean stream: generator seeded 0x7FFFFFFF, 1000 valid bits → `locked` rises after the 31st bit and `err_count` = 0 throughout.
- Single flip: invert bit 200 of a clean locked stream → `err_pulse` on bits 200, 228 and 231; `err_count` = 3; `locked` stays 1.
- Gapped valid: `din_valid` toggling every cycle with a clean stream → identical to the clean-stream result, no errors.
- Random data after lock, default parameters → `locked` falls on the 8th error within a 64-bit window.
  - With `PRBS31_CHK_AUTORESYNC_EN`: SEED is re-entered and `locked` re-asserts on clean data.
  - Without it: `locked` stays 0 until `clear`.
- Boundaries:
  - 100 zero bits → `locked` never rises.
  - `ERR_W` = 4 with more than 16 errors → `err_count` holds at 15.
